alu_operand_stage: RTL and testbench

- Parametrised successor to the combinational ALU operand mux; sits in the decode→execute boundary of the RV64 pipeline.
- Selects ALU operands from PC, immediate or register data, and applies operand forwarding from NFWD later pipeline stages.
- Detects load-use hazards and registers the result into a one-entry execute-input register with a valid/ready handshake and flush.

---
 rtl/alu_operand_stage_pkg.sv | 48 ++++
 rtl/alu_operand_stage_fwd_select.sv | 28 ++
 rtl/alu_operand_stage.sv | 130 +++++++++++++
 tb/tb_alu_operand_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Operation encoding and operand-class predicates shared by the ALU operand stage.
package alu_operand_stage_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_ADDI  = 5'd6,
    OP_ANDI  = 5'd7,
    OP_ORI   = 5'd8,
    OP_XORI  = 5'd9,
    OP_JAL   = 5'd10,
    OP_JALR  = 5'd11,
    OP_AUIPC = 5'd12,
    OP_LD    = 5'd13,
    OP_SD    = 5'd14,
    OP_ADDW  = 5'd15,
    OP_SUBW  = 5'd16,
    OP_ADDIW = 5'd17
  } op_t;

  function automatic logic is_pc_op(input op_t op);
    return op inside {OP_JAL, OP_JALR, OP_AUIPC};
  endfunction

  function automatic logic is_imm_op(input op_t op);
    return op inside {OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_JAL, OP_JALR,
                      OP_AUIPC, OP_SD, OP_LD, OP_ADDIW};
  endfunction

  function automatic logic is_word_op(input op_t op);
    return op inside {OP_ADDW, OP_SUBW, OP_ADDIW};
  endfunction

  // JALR reads rs1 as its jump base even though alu_in1 carries the PC.
  function automatic logic uses_rs1(input op_t op);
    return !is_pc_op(op) || (op == OP_JALR);
  endfunction

  // Stores take the immediate as address offset but still need rs2 as data.
  function automatic logic uses_rs2(input op_t op);
    return !is_imm_op(op) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Picks the youngest live forwarding source matching a register index, else the RF value.
module fwd_select #(
  parameter int NFWD = 3,
  parameter int XLEN = 64
) (
  input  logic [4:0]           i_src,
  input  logic [XLEN-1:0]      i_rf_data,
  input  logic [NFWD-1:0]      i_fwd_valid,
  input  logic [NFWD-1:0]      i_fwd_pending,
  input  logic [NFWD*5-1:0]    i_fwd_rd,
  input  logic [NFWD*XLEN-1:0] i_fwd_data,
  output logic [XLEN-1:0]      o_data,
  output logic                 o_pending
);

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    o_data    = i_rf_data;
    o_pending = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (i_src != 5'd0 && i_fwd_valid[i] && i_fwd_rd[i*5 +: 5] == i_src) begin
        o_data    = i_fwd_data[i*XLEN +: XLEN];
        o_pending = i_fwd_pending[i];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/execute boundary: operand select with forwarding, load-use stall, one-entry output register.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NFWD      = 3,
  parameter int SEXT_WORD = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  op_t                  in_op,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [XLEN-1:0]      in_rd1,
  input  logic [XLEN-1:0]      in_rd2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output op_t                  out_op,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_alu_in1,
  output logic [XLEN-1:0]      out_alu_in2,
  output logic [XLEN-1:0]      out_store_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  logic [XLEN-1:0]  w_rs1_val_p0, w_rs2_val_p0;
  logic             w_rs1_pend_p0, w_rs2_pend_p0;
  logic [XLEN-1:0]  w_alu_in1_p0, w_alu_in2_p0;
  logic             w_haz_p0, w_load_p0;

  logic             r_vld_p1;
  op_t              r_op_p1;
  logic [XLEN-1:0]  r_pc_p1, r_alu_in1_p1, r_alu_in2_p1, r_store_data_p1;
  logic [CNT_W-1:0] r_stall_cnt;

  fwd_select #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd_rs1 (
    .i_src         (in_rs1),
    .i_rf_data     (in_rd1),
    .i_fwd_valid   (fwd_valid),
    .i_fwd_pending (fwd_pending),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_data        (w_rs1_val_p0),
    .o_pending     (w_rs1_pend_p0)
  );

  fwd_select #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd_rs2 (
    .i_src         (in_rs2),
    .i_rf_data     (in_rd2),
    .i_fwd_valid   (fwd_valid),
    .i_fwd_pending (fwd_pending),
    .i_fwd_rd      (fwd_rd),
    .i_fwd_data    (fwd_data),
    .o_data        (w_rs2_val_p0),
    .o_pending     (w_rs2_pend_p0)
  );

  // Stage p0: operand select, word sign-extension, hazard and handshake.
  always_comb begin
    w_alu_in1_p0 = is_pc_op(in_op)  ? in_pc  : w_rs1_val_p0;
    w_alu_in2_p0 = is_imm_op(in_op) ? in_imm : w_rs2_val_p0;
    if (SEXT_WORD != 0 && is_word_op(in_op)) begin
      w_alu_in1_p0 = sext_word(w_alu_in1_p0);
      w_alu_in2_p0 = sext_word(w_alu_in2_p0);
    end
  end

  assign w_haz_p0  = in_valid && ((uses_rs1(in_op) && w_rs1_pend_p0) ||
                                  (uses_rs2(in_op) && w_rs2_pend_p0));
  assign in_ready  = (!r_vld_p1 || out_ready) && !w_haz_p0 && !flush;
  assign w_load_p0 = in_valid && in_ready;

  // Stage p1: execute-input register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1        <= 1'b0;
      r_op_p1         <= OP_NOP;
      r_pc_p1         <= '0;
      r_alu_in1_p1    <= '0;
      r_alu_in2_p1    <= '0;
      r_store_data_p1 <= '0;
    end else begin
      if (flush) begin
        r_vld_p1 <= 1'b0;
      end else if (w_load_p0) begin
        r_vld_p1 <= 1'b1;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_load_p0) begin
        r_op_p1         <= in_op;
        r_pc_p1         <= in_pc;
        r_alu_in1_p1    <= w_alu_in1_p0;
        r_alu_in2_p1    <= w_alu_in2_p0;
        r_store_data_p1 <= w_rs2_val_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_haz_p0 && !flush && r_stall_cnt != {CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid      = r_vld_p1;
  assign out_op         = r_op_p1;
  assign out_pc         = r_pc_p1;
  assign out_alu_in1    = r_alu_in1_p1;
  assign out_alu_in2    = r_alu_in2_p1;
  assign out_store_data = r_store_data_p1;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage; small stall counter so saturation is reachable.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int XLEN  = 64;
  localparam int NFWD  = 3;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  op_t               in_op, out_op;
  logic [XLEN-1:0]   in_pc, in_imm, in_rd1, in_rd2;
  logic [4:0]        in_rs1, in_rs2;
  logic [NFWD-1:0]   fwd_valid, fwd_pending;
  logic [NFWD*5-1:0] fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [XLEN-1:0]   out_pc, out_alu_in1, out_alu_in2, out_store_data;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD), .SEXT_WORD(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_pc(out_pc), .out_alu_in1(out_alu_in1), .out_alu_in2(out_alu_in2),
    .out_store_data(out_store_data), .stall_cnt(stall_cnt)
  );

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_op = OP_NOP; in_pc = '0; in_imm = '0;
    in_rs1 = 0; in_rs2 = 0; in_rd1 = '0; in_rd2 = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  task automatic drive(input op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd1 = rd1; in_rd2 = rd2; in_pc = pc; in_imm = imm;
  endtask

  task automatic test_reset();
    reset = 0; out_ready = 1; clear_inputs();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_op !== OP_NOP) begin failures++; $display("FAIL reset_op got=%0d exp=%0d", out_op, OP_NOP); end
    checks++; if ({out_pc, out_alu_in1, out_alu_in2, out_store_data} !== '0) begin failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", out_pc, out_alu_in1, out_alu_in2, out_store_data); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    @(posedge clk); #1 reset = 1;
  endtask

  task automatic test_addi();
    @(posedge clk); #1;
    drive(OP_ADDI, 5'd1, 5'd0, 64'h10, 64'h0, 64'h0, 64'h5);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
    checks++; if (out_alu_in1 !== 64'h10) begin failures++; $display("FAIL addi_in1 got=%h exp=10", out_alu_in1); end
    checks++; if (out_alu_in2 !== 64'h5) begin failures++; $display("FAIL addi_in2 got=%h exp=5", out_alu_in2); end
    checks++; if (out_op !== OP_ADDI) begin failures++; $display("FAIL addi_op got=%0d exp=%0d", out_op, OP_ADDI); end
    in_valid = 0;
  endtask

  task automatic test_auipc();
    @(posedge clk); #1;
    drive(OP_AUIPC, 5'd4, 5'd0, 64'h55, 64'h0, 64'h8000_0000, 64'h1000);
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'h8000_0000) begin failures++; $display("FAIL auipc_in1 got=%h exp=80000000", out_alu_in1); end
    checks++; if (out_alu_in2 !== 64'h1000) begin failures++; $display("FAIL auipc_in2 got=%h exp=1000", out_alu_in2); end
    checks++; if (out_pc !== 64'h8000_0000) begin failures++; $display("FAIL auipc_pc got=%h exp=80000000", out_pc); end
    in_valid = 0;
  endtask

  task automatic test_forward_priority();
    @(posedge clk); #1;
    fwd_valid = 3'b101; fwd_rd[4:0] = 5'd3; fwd_rd[9:5] = 5'd9; fwd_rd[14:10] = 5'd3;
    fwd_data[63:0] = 64'hA; fwd_data[127:64] = 64'hC; fwd_data[191:128] = 64'hB;
    drive(OP_ADD, 5'd3, 5'd4, 64'h111, 64'h222, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'hA) begin failures++; $display("FAIL fwd_youngest got=%h exp=a", out_alu_in1); end
    checks++; if (out_alu_in2 !== 64'h222) begin failures++; $display("FAIL fwd_nomatch got=%h exp=222", out_alu_in2); end
    checks++; if (out_store_data !== 64'h222) begin failures++; $display("FAIL fwd_store got=%h exp=222", out_store_data); end
    fwd_valid = 3'b100;
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'hB) begin failures++; $display("FAIL fwd_older got=%h exp=b", out_alu_in1); end
    fwd_valid = 3'b111; fwd_rd = '0;
    drive(OP_ADD, 5'd0, 5'd0, 64'h333, 64'h444, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'h333) begin failures++; $display("FAIL fwd_x0_rs1 got=%h exp=333", out_alu_in1); end
    checks++; if (out_alu_in2 !== 64'h444) begin failures++; $display("FAIL fwd_x0_rs2 got=%h exp=444", out_alu_in2); end
    clear_inputs();
  endtask

  task automatic test_hazard();
    @(posedge clk); #1;
    fwd_valid = 3'b010; fwd_pending = 3'b010; fwd_rd[9:5] = 5'd7; fwd_data[127:64] = 64'h77;
    drive(OP_ADD, 5'd1, 5'd7, 64'h1, 64'h2, 64'h0, 64'h0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_ready got=%0b exp=0", in_ready); end
    in_op = OP_ADDI; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_imm_no_rs2 got=%0b exp=1", in_ready); end
    in_op = OP_SD; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_sd_rs2 got=%0b exp=0", in_ready); end
    in_op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL haz_bubble got=%0b exp=0", out_valid); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL haz_stall got=%0d exp=3", stall_cnt); end
    fwd_pending = '0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_release got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_alu_in2 !== 64'h77) begin failures++; $display("FAIL haz_load got=%0b/%h exp=1/77", out_valid, out_alu_in2); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL haz_stall_hold got=%0d exp=3", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_word();
    @(posedge clk); #1;
    drive(OP_ADDW, 5'd1, 5'd2, 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0005, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL word_in1 got=%h exp=ffffffff80000000", out_alu_in1); end
    checks++; if (out_alu_in2 !== 64'h5) begin failures++; $display("FAIL word_in2 got=%h exp=5", out_alu_in2); end
    checks++; if (out_store_data !== 64'h0000_0001_0000_0005) begin failures++; $display("FAIL word_store got=%h exp=100000005", out_store_data); end
    drive(OP_ADDIW, 5'd1, 5'd0, 64'h0000_0001_FFFF_FFFF, 64'h0, 64'h0, 64'h0000_0000_7FFF_FFFF);
    @(posedge clk); #1;
    checks++; if (out_alu_in1 !== 64'hFFFF_FFFF_FFFF_FFFF || out_alu_in2 !== 64'h7FFF_FFFF) begin failures++; $display("FAIL wordi got=%h/%h exp=ffffffffffffffff/7fffffff", out_alu_in1, out_alu_in2); end
    in_valid = 0;
  endtask

  task automatic test_hold_flush();
    @(posedge clk); #1;
    out_ready = 0;
    drive(OP_ADD, 5'd1, 5'd2, 64'h1234, 64'h5678, 64'h40, 64'h0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_alu_in1 !== 64'h1234) begin failures++; $display("FAIL hold_load got=%0b/%h exp=1/1234", out_valid, out_alu_in1); end
    drive(OP_ADDI, 5'd1, 5'd0, 64'h999, 64'h0, 64'h80, 64'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_alu_in1 !== 64'h1234 || out_alu_in2 !== 64'h5678 ||
          out_pc !== 64'h40 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%0b/%h/%h/%h/rdy%0b exp=1/1234/5678/40/rdy0",
                 c, out_valid, out_alu_in1, out_alu_in2, out_pc, in_ready);
      end
    end
    flush = 1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL flush_stall got=%0d exp=3", stall_cnt); end
    out_ready = 1;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive(OP_ADDI, 5'd1, 5'd0, 64'h100, 64'h0, 64'h0, 64'h1);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_alu_in1 !== 64'h100) begin failures++; $display("FAIL b2b_first got=%0b/%h exp=1/100", out_valid, out_alu_in1); end
    drive(OP_ADDI, 5'd1, 5'd0, 64'h200, 64'h0, 64'h0, 64'h2);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_alu_in1 !== 64'h200 || out_alu_in2 !== 64'h2) begin failures++; $display("FAIL b2b_second got=%0b/%h/%h exp=1/200/2", out_valid, out_alu_in1, out_alu_in2); end
    in_valid = 0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd[4:0] = 5'd5;
    drive(OP_ADD, 5'd5, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    flush = 1;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL sat_flush_nocount got=%0d exp=3", stall_cnt); end
    flush = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 3'd5) begin failures++; $display("FAIL sat_count got=%0d exp=5", stall_cnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 0;
    drive(OP_ADD, 5'd1, 5'd2, 64'hABC, 64'hDEF, 64'h0, 64'h0);
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0b exp=1", out_valid); end
    #1 reset = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_alu_in1 !== '0 || out_op !== OP_NOP) begin failures++; $display("FAIL rstmid_entry got=%0b/%h/%0d exp=0/0/0", out_valid, out_alu_in1, out_op); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rstmid_stall got=%0d exp=0", stall_cnt); end
    @(negedge clk); reset = 1; out_ready = 1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_auipc();
    test_forward_priority();
    test_hazard();
    test_word();
    test_hold_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
